uart_rx_fmt: RTL and testbench

Parametrised UART receiver for the serial input path of the host link. It generalises the fixed 8N1 receiver: configurable data width, optional parity, and one or two stop bits. It adds start-bit glitch rejection, framing/parity/overrun error reporting, and a valid/ready output handshake with a one-entry holding register. It sits between the board RX pin and the command/byte consumer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_rx_fmt.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fmt.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM state encoding and
// the bit-period length helper used by the receiver (and the future transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } uart_parity_e;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  function automatic int calc_bps_cnt(input int clk_fre, input int bps);
    return clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-runs over one bit period while clr is low, with a
// tick at the chosen sample point and a tick on the last cycle of the period.
module uart_baud_cnt #(
  parameter int BPS_CNT   = 16,
  parameter int SAMPLE_PT = BPS_CNT / 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CW = $clog2(BPS_CNT);

  logic [CW-1:0] clk_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt <= '0;
    end else if (clr || end_tick) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  assign mid_tick = (clk_cnt == CW'(SAMPLE_PT));
  assign end_tick = (clk_cnt == CW'(BPS_CNT - 1));

endmodule

// File: rtl/uart_rx_fmt.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop
// bits) with a one-entry valid/ready holding register. Define UART_RX_MAJORITY_EN
// to decide each bit by a 3-sample majority vote instead of a single mid sample.
module uart_rx_fmt
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 200_000_000,
  parameter int BPS       = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int   BPS_CNT    = calc_bps_cnt(CLK_FRE, BPS);
  localparam int   MID        = BPS_CNT >> 1;
  localparam int   BW         = (DATA_BITS > 8) ? 4 : 3;
  localparam logic PAR_EN     = (PARITY != int'(PAR_NONE));
  localparam logic PAR_IS_ODD = (PARITY == int'(PAR_ODD));

  if (BPS_CNT < 8) begin : g_bps_chk
    $error("uart_rx_fmt: CLK_FRE/BPS must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("uart_rx_fmt: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_fmt: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_fmt: STOP_BITS must be 1 or 2");
  end

  logic                 rxd_meta, rxd_sync, rxd_prev;
  logic                 fall_edge;
  logic                 bit_val;
  logic                 mid_tick, end_tick;
  logic                 cnt_clr;
  logic                 last_stop, frame_done;
  uart_state_t          state;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad, frm_bad;

  // Synchroniser flops idle high so releasing reset never looks like a start bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall_edge = rxd_prev & ~rxd_sync;

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_PT = MID + 1;

  logic [1:0] samp_hist;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      samp_hist <= 2'b11;
    end else begin
      samp_hist <= {samp_hist[0], rxd_sync};
    end
  end

  assign bit_val = (samp_hist[1] & samp_hist[0]) | (samp_hist[1] & rxd_sync) |
                   (samp_hist[0] & rxd_sync);
`else
  localparam int SAMPLE_PT = MID;

  assign bit_val = rxd_sync;
`endif

  assign cnt_clr = (state == ST_IDLE);

  uart_baud_cnt #(
    .BPS_CNT  (BPS_CNT),
    .SAMPLE_PT(SAMPLE_PT)
  ) u_baud_cnt (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (cnt_clr),
    .mid_tick (mid_tick),
    .end_tick (end_tick)
  );

  assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_done = (state == ST_STOP) && mid_tick && last_stop;
  assign rx_busy    = (state != ST_IDLE);

  // Leaving STOP at the last sample point lets a directly following start bit be caught.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
      frm_bad   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall_edge) begin
            state    <= ST_START;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bad  <= 1'b0;
            frm_bad  <= 1'b0;
          end
        end
        ST_START: begin
          if (mid_tick && bit_val) begin
            state <= ST_IDLE;
          end else if (end_tick) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid_tick) begin
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
          end
          if (end_tick) begin
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              state <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (mid_tick) begin
            par_bad <= (^shift_reg) ^ bit_val ^ PAR_IS_ODD;
          end
          if (end_tick) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (mid_tick) begin
            if (!bit_val) begin
              frm_bad <= 1'b1;
            end
            if (last_stop) begin
              state <= ST_IDLE;
            end
          end else if (end_tick) begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A full register with no accept in the completion cycle keeps the old word.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          frame_err  <= frm_bad | ~bit_val;
          parity_err <= PAR_EN & par_bad;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fmt.sv
// Self-checking bench for uart_rx_fmt: an 8N1 instance and an 8E1 instance
// checked every cycle against a frame-level timing/holding-register model.
module tb_uart_rx_fmt;

  localparam int CLK_FRE = 1_600_000;
  localparam int BPS     = 100_000;
  localparam int B       = 16;
  localparam int MID     = 8;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       rxd_a     = 1'b1;
  logic       rxd_b     = 1'b1;
  logic       ready_a   = 1'b1;
  logic       ready_b   = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;

  int         cyc     = 0;
  int         n_total = 0;
  int         n_pass  = 0;
  logic       chk_en  = 1'b0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic       m_valid[2];
  logic [7:0] m_data[2];
  logic       m_fe[2], m_pe[2], m_ovr[2];

  int         rise_cyc[2];
  logic [7:0] rise_data[2];
  logic       rise_fe[2], rise_pe[2];
  int         valid_hi_cnt[2];
  int         ovr_cnt[2];
  logic       prev_valid[2];

  always #5 sys_clk = ~sys_clk;

  uart_rx_fmt #(
    .CLK_FRE(CLK_FRE), .BPS(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (rxd_a),
    .rx_data   (data_a),
    .rx_valid  (valid_a),
    .rx_ready  (ready_a),
    .frame_err (ferr_a),
    .parity_err(perr_a),
    .overrun   (ovr_a),
    .rx_busy   (busy_a)
  );

  uart_rx_fmt #(
    .CLK_FRE(CLK_FRE), .BPS(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (rxd_b),
    .rx_data   (data_b),
    .rx_valid  (valid_b),
    .rx_ready  (ready_b),
    .frame_err (ferr_b),
    .parity_err(perr_b),
    .overrun   (ovr_b),
    .rx_busy   (busy_b)
  );

  task automatic checkVal(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Holding register as described: load on completion if empty or accepted, else overrun.
  task automatic modelApply(input int idx, input bit hit, input exp_t e, input logic rdy);
    m_ovr[idx] = 1'b0;
    if (hit) begin
      if (!m_valid[idx] || rdy) begin
        m_valid[idx] = 1'b1;
        m_data[idx]  = e.data;
        m_fe[idx]    = e.fe;
        m_pe[idx]    = e.pe;
      end else begin
        m_ovr[idx] = 1'b1;
      end
    end else if (m_valid[idx] && rdy) begin
      m_valid[idx] = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    bit   hit;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_data[i] = 8'h00; m_fe[i] = 1'b0; m_pe[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 2; i++) begin
          m_valid[i] = 1'b0; m_data[i] = 8'h00; m_fe[i] = 1'b0; m_pe[i] = 1'b0; m_ovr[i] = 1'b0;
        end
      end else begin
        hit = (q_a.size() > 0) && (q_a[0].due == cyc);
        if (hit) e = q_a.pop_front();
        modelApply(0, hit, e, ready_a);
        hit = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (hit) e = q_b.pop_front();
        modelApply(1, hit, e, ready_b);
      end
    end
  end

  task automatic checkOutput(input int idx, input logic v, input logic [7:0] d,
                             input logic fe, input logic pe, input logic ov);
    string tag = (idx == 0) ? "a" : "b";
    if (!sys_rst_n) begin
      checkVal({tag, "_rst_valid"}, int'(v), 0);
      checkVal({tag, "_rst_data"}, int'(d), 0);
      checkVal({tag, "_rst_ferr"}, int'(fe), 0);
      checkVal({tag, "_rst_perr"}, int'(pe), 0);
      checkVal({tag, "_rst_ovr"}, int'(ov), 0);
    end else begin
      checkVal({tag, "_valid"}, int'(v), int'(m_valid[idx]));
      checkVal({tag, "_overrun"}, int'(ov), int'(m_ovr[idx]));
      if (m_valid[idx]) begin
        checkVal({tag, "_data"}, int'(d), int'(m_data[idx]));
        checkVal({tag, "_frame_err"}, int'(fe), int'(m_fe[idx]));
        checkVal({tag, "_parity_err"}, int'(pe), int'(m_pe[idx]));
      end
    end
    if (v && !prev_valid[idx]) begin
      rise_cyc[idx]  = cyc;
      rise_data[idx] = d;
      rise_fe[idx]   = fe;
      rise_pe[idx]   = pe;
    end
    if (v) valid_hi_cnt[idx]++;
    if (ov) ovr_cnt[idx]++;
    prev_valid[idx] = v;
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      checkOutput(0, valid_a, data_a, ferr_a, perr_a, ovr_a);
      checkOutput(1, valid_b, data_b, ferr_b, perr_b, ovr_b);
    end
  end

  task automatic setLine(input int idx, input logic v);
    if (idx == 0) rxd_a = v;
    else          rxd_b = v;
  endtask

  // Sends one frame; with abort_bit >= 0 it asserts reset during that data bit and returns with reset held.
  task automatic applyStimulus(input int idx, input logic [7:0] data, input bit use_par,
                               input logic pbit, input logic stop_lvl, input int abort_bit,
                               output int start_cyc);
    logic [10:0] fb;
    int          nb;
    exp_t        e;
    nb = use_par ? 11 : 10;
    fb = '1;
    fb[0]   = 1'b0;
    fb[8:1] = data;
    if (use_par) begin
      fb[9]  = pbit;
      fb[10] = stop_lvl;
    end else begin
      fb[9] = stop_lvl;
    end
    @(posedge sys_clk); #1;
    start_cyc     = cyc;
    rise_cyc[idx] = -1;
    if (abort_bit < 0) begin
      e.due  = start_cyc + 1 + 2 + (nb - 1) * B + MID + 1;
      e.data = data;
      e.fe   = !stop_lvl;
      e.pe   = use_par ? ((^data) ^ pbit) : 1'b0;
      if (idx == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      setLine(idx, fb[i]);
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (5) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        setLine(idx, 1'b1);
        return;
      end
      repeat (B) @(posedge sys_clk);
      #1;
    end
    setLine(idx, 1'b1);
  endtask

  initial begin
    int  sc;
    bit  seen_hi, cleared;
    for (int i = 0; i < 2; i++) begin
      rise_cyc[i] = -1; rise_data[i] = 8'h00; rise_fe[i] = 1'b0; rise_pe[i] = 1'b0;
      valid_hi_cnt[i] = 0; ovr_cnt[i] = 0; prev_valid[i] = 1'b0;
    end
    #2;
    sys_rst_n = 1'b0;
    chk_en    = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checkVal("reset_valid", int'(valid_a), 0);
    checkVal("reset_busy", int'(busy_a), 0);
    checkVal("reset_data", int'(data_a), 0);
    checkVal("reset_overrun", int'(ovr_a), 0);
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    valid_hi_cnt[0] = 0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("a5_latency", rise_cyc[0] - (sc + 1), 155);
    checkVal("a5_data", int'(rise_data[0]), 'hA5);
    checkVal("a5_frame_err", int'(rise_fe[0]), 0);
    checkVal("a5_parity_err", int'(rise_pe[0]), 0);
    checkVal("a5_valid_cycles", valid_hi_cnt[0], 1);

    applyStimulus(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("par1_latency", rise_cyc[1] - (sc + 1), 171);
    checkVal("par1_data", int'(rise_data[1]), 'h3C);
    checkVal("par1_parity_err", int'(rise_pe[1]), 1);
    applyStimulus(1, 8'h3C, 1'b1, 1'b0, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("par0_data", int'(rise_data[1]), 'h3C);
    checkVal("par0_parity_err", int'(rise_pe[1]), 0);

    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b0, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("ferr_data", int'(rise_data[0]), 'h55);
    checkVal("ferr_flag", int'(rise_fe[0]), 1);
    applyStimulus(0, 8'h12, 1'b0, 1'b0, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("after_ferr_data", int'(rise_data[0]), 'h12);
    checkVal("after_ferr_flag", int'(rise_fe[0]), 0);

    valid_hi_cnt[0] = 0;
    seen_hi = 1'b0;
    cleared = 1'b0;
    @(posedge sys_clk); #1;
    rxd_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (busy_a) seen_hi = 1'b1;
    end
    @(posedge sys_clk); #1;
    rxd_a = 1'b1;
    for (int i = 0; i < 1 + MID + 2; i++) begin
      @(negedge sys_clk);
      if (busy_a) seen_hi = 1'b1;
      if (!busy_a && seen_hi) begin
        cleared = 1'b1;
        break;
      end
    end
    checkVal("glitch_busy_seen", int'(seen_hi), 1);
    checkVal("glitch_busy_cleared", int'(cleared), 1);
    repeat (200) @(posedge sys_clk);
    checkVal("glitch_no_valid", valid_hi_cnt[0], 0);

    #1;
    ready_a    = 1'b0;
    ovr_cnt[0] = 0;
    applyStimulus(0, 8'h01, 1'b0, 1'b0, 1'b1, -1, sc);
    applyStimulus(0, 8'h02, 1'b0, 1'b0, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("ovr_pulses", ovr_cnt[0], 1);
    checkVal("ovr_kept_data", int'(data_a), 'h01);
    checkVal("ovr_still_valid", int'(valid_a), 1);
    #1;
    ready_a = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkVal("accept_clears_valid", int'(valid_a), 0);

    applyStimulus(0, 8'h7E, 1'b0, 1'b0, 1'b1, 3, sc);
    @(negedge sys_clk);
    checkVal("midframe_rst_busy", int'(busy_a), 0);
    checkVal("midframe_rst_data", int'(data_a), 0);
    checkVal("midframe_rst_valid", int'(valid_a), 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b1, -1, sc);
    repeat (10) @(posedge sys_clk);
    checkVal("post_rst_latency", rise_cyc[0] - (sc + 1), 155);
    checkVal("post_rst_data", int'(rise_data[0]), 'h81);
    checkVal("post_rst_frame_err", int'(rise_fe[0]), 0);

    repeat (20) @(posedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
